bcd_mod_counter: RTL and testbench

Parametrised, fully synchronous multi-digit modulo-RADIX counter. It is the successor to the single-digit ripple decade counter. All digits update on the same clk edge; there are no ripple clocks. It adds:
- configurable digit count and radix
- count enable
- up/down direction
- synchronous parallel load
- a terminal-count output for cascading

It is used as the event/time counter feeding display and timer logic.

---
 rtl/bcd_mod_counter.sv | 91 +++++++++
 tb/tb_bcd_mod_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Fully synchronous multi-digit modulo-RADIX counter with load, enable, direction and cascade carry.
// Define BCD_MOD_COUNTER_SATURATE_EN to make counting saturate at the terminal state instead of wrapping.
module bcd_mod_counter #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned RADIX  = 10,
    localparam int unsigned W     = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         load_err
);

    localparam logic [3:0] MAX_DIG = 4'(RADIX - 1);
    localparam logic [4:0] RADIX_5 = 5'(RADIX);

    logic [W-1:0] count_q, count_d;
    logic         load_err_q, load_err_d;
    logic [3:0]   term_val;
    logic         all_term;
    logic         sat_hold;
    logic [3:0]   dig;
    logic         carry;

    assign term_val = up ? MAX_DIG : 4'd0;

    always_comb begin
        all_term = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (count_q[4*k +: 4] != term_val) begin
                all_term = 1'b0;
            end
        end
    end

`ifdef BCD_MOD_COUNTER_SATURATE_EN
    assign sat_hold = all_term;
`else
    assign sat_hold = 1'b0;
`endif

    // Digit k steps only while every lower digit sits at its terminal value.
    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        dig        = 4'd0;
        carry      = 1'b1;
        if (load) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                dig = din[4*k +: 4];
                if ({1'b0, dig} >= RADIX_5) begin
                    dig        = MAX_DIG;
                    load_err_d = 1'b1;
                end
                count_d[4*k +: 4] = dig;
            end
        end else if (en && !sat_hold) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                dig = count_q[4*k +: 4];
                if (carry) begin
                    if (up) begin
                        count_d[4*k +: 4] = (dig == MAX_DIG) ? 4'd0 : dig + 4'd1;
                    end else begin
                        count_d[4*k +: 4] = (dig == 4'd0) ? MAX_DIG : dig - 4'd1;
                    end
                end
                carry = carry & (dig == term_val);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = count_q;
    assign load_err = load_err_q;
    assign tc       = en & all_term;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed self-checking bench for bcd_mod_counter (DIGITS=2, RADIX=10).
// Build with BCD_MOD_COUNTER_SATURATE_EN defined to exercise the saturating variant.
module tb_bcd_mod_counter;

    logic       clk;
    logic       rst_l;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] din;
    logic [7:0] q;
    logic       tc;
    logic       load_err;

    int checks;
    int errors;

    bcd_mod_counter #(.DIGITS(2), .RADIX(10)) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .en       (en),
        .up       (up),
        .load     (load),
        .din      (din),
        .q        (q),
        .tc       (tc),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD_MOD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] value);
        load = 1'b1;
        en   = 1'b0;
        din  = value;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q actual=%h expected=00", q); end
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err actual=%b expected=0", load_err); end
        rst_l = 1'b1;
        step();
        do_load(8'h35);
        en = 1'b1;
        up = 1'b1;
        step();
        step();
        checks++;
        if (q !== 8'h37) begin errors++; $display("[TB] FAIL pre_reset_q actual=%h expected=37", q); end
        load = 1'b1;
        din  = 8'h5C;
        step();
        load = 1'b0;
        #2;
        rst_l = 1'b0;
        up    = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL async_reset_q actual=%h expected=00", q); end
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_err actual=%b expected=0", load_err); end
        checks++;
        if (tc !== 1'b1) begin errors++; $display("[TB] FAIL reset_tc_down actual=%b expected=1", tc); end
        en = 1'b0;
        step();
        step();
        #2;
        rst_l = 1'b1;
        step();
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL post_release_q actual=%h expected=00", q); end
        checks++;
        if (tc !== 1'b0) begin errors++; $display("[TB] FAIL post_release_tc actual=%b expected=0", tc); end
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_last;
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (q !== to_bcd(i)) begin errors++; $display("[TB] FAIL up_walk i=%0d actual=%h expected=%h", i, q, to_bcd(i)); end
            checks++;
            if (tc !== (i == 99)) begin errors++; $display("[TB] FAIL up_tc i=%0d actual=%b expected=%b", i, tc, (i == 99)); end
            step();
        end
        exp_last = SAT ? 8'h99 : 8'h00;
        checks++;
        if (q !== exp_last) begin errors++; $display("[TB] FAIL up_wrap actual=%h expected=%h", q, exp_last); end
        en = 1'b0;
    endtask

    task automatic test_down_flip();
        logic [7:0] exp_wrap;
        do_load(8'h10);
        checks++;
        if (q !== 8'h10) begin errors++; $display("[TB] FAIL load10 actual=%h expected=10", q); end
        en = 1'b1;
        up = 1'b0;
        step();
        checks++;
        if (q !== 8'h09) begin errors++; $display("[TB] FAIL down1 actual=%h expected=09", q); end
        step();
        checks++;
        if (q !== 8'h08) begin errors++; $display("[TB] FAIL down2 actual=%h expected=08", q); end
        up = 1'b1;
        step();
        checks++;
        if (q !== 8'h09) begin errors++; $display("[TB] FAIL flip_up1 actual=%h expected=09", q); end
        checks++;
        if (tc !== 1'b0) begin errors++; $display("[TB] FAIL flip_tc09 actual=%b expected=0", tc); end
        step();
        checks++;
        if (q !== 8'h10) begin errors++; $display("[TB] FAIL flip_up2 actual=%h expected=10", q); end
        do_load(8'h00);
        en = 1'b1;
        up = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin errors++; $display("[TB] FAIL down_tc00 actual=%b expected=1", tc); end
        step();
        exp_wrap = SAT ? 8'h00 : 8'h99;
        checks++;
        if (q !== exp_wrap) begin errors++; $display("[TB] FAIL down_wrap actual=%h expected=%h", q, exp_wrap); end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        load = 1'b1;
        en   = 1'b1;
        up   = 1'b1;
        din  = 8'h5C;
        step();
        checks++;
        if (q !== 8'h59) begin errors++; $display("[TB] FAIL clamp_low actual=%h expected=59", q); end
        checks++;
        if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL clamp_err actual=%b expected=1", load_err); end
        load = 1'b0;
        step();
        checks++;
        if (q !== 8'h60) begin errors++; $display("[TB] FAIL after_clamp actual=%h expected=60", q); end
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear actual=%b expected=0", load_err); end
        load = 1'b1;
        din  = 8'hF3;
        step();
        checks++;
        if (q !== 8'h93) begin errors++; $display("[TB] FAIL clamp_high actual=%h expected=93", q); end
        checks++;
        if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL clamp_high_err actual=%b expected=1", load_err); end
        din = 8'h99;
        step();
        checks++;
        if (q !== 8'h99) begin errors++; $display("[TB] FAIL legal_load actual=%h expected=99", q); end
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL legal_err actual=%b expected=0", load_err); end
        load = 1'b0;
        en   = 1'b0;
    endtask

    task automatic test_hold();
        do_load(8'h42);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up = i[0];
            step();
            checks++;
            if (q !== 8'h42) begin errors++; $display("[TB] FAIL hold_q i=%0d actual=%h expected=42", i, q); end
            checks++;
            if (tc !== 1'b0) begin errors++; $display("[TB] FAIL hold_tc i=%0d actual=%b expected=0", i, tc); end
        end
    endtask

    task automatic test_saturate();
        do_load(8'h98);
        en = 1'b1;
        up = 1'b1;
        step();
        checks++;
        if (q !== 8'h99) begin errors++; $display("[TB] FAIL sat_up1 actual=%h expected=99", q); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (q !== 8'h99) begin errors++; $display("[TB] FAIL sat_up_hold actual=%h expected=99", q); end
            checks++;
            if (tc !== 1'b1) begin errors++; $display("[TB] FAIL sat_up_tc actual=%b expected=1", tc); end
        end
        do_load(8'h01);
        en = 1'b1;
        up = 1'b0;
        step();
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL sat_dn1 actual=%h expected=00", q); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (q !== 8'h00) begin errors++; $display("[TB] FAIL sat_dn_hold actual=%h expected=00", q); end
            checks++;
            if (tc !== 1'b1) begin errors++; $display("[TB] FAIL sat_dn_tc actual=%b expected=1", tc); end
        end
        en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_l  = 1'b0;
        en     = 1'b0;
        up     = 1'b1;
        load   = 1'b0;
        din    = 8'h00;
        #12;
        test_reset();
        test_up_wrap();
        test_down_flip();
        test_load_clamp();
        test_hold();
        if (SAT) begin
            test_saturate();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
